// File: rtl/ptmch_pkg.sv
// ptmch_pkg: shared definitions for the multi-channel SPI-programmed trigger
// generator (ptmch_trg_mc) and its per-channel engine (ptmch_trg_ch).
// Contents: frame geometry, broadcast channel index, opcode and FSM state
// enums, plus a small opcode classification helper. No ports.
package ptmch_pkg;

  localparam int         FRAME_W  = 24;
  localparam logic [3:0] BCAST_CH = 4'hF;

  typedef enum logic [3:0] {
    OP_DELAY  = 4'h1,
    OP_WIDTH  = 4'h2,
    OP_PERIOD = 4'h3,
    OP_MODE   = 4'h4,
    OP_FIRE   = 4'h8,
    OP_STOP   = 4'h9
  } opcode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DELAY = 2'd1,
    ST_PULSE = 2'd2,
    ST_GAP   = 2'd3
  } ch_state_e;

  function automatic logic is_reg_write(input logic [3:0] op);
    return (op == OP_DELAY) || (op == OP_WIDTH) ||
           (op == OP_PERIOD) || (op == OP_MODE);
  endfunction

endpackage

// File: rtl/ptmch_trg_ch.sv
// ptmch_trg_ch: one trigger channel. Holds the DELAY/WIDTH/PERIOD/MODE
// registers, latches them at FIRE and runs the IDLE/DELAY/PULSE/GAP sequence.
// Ports:
//   clk_i, rst_ni         clock, synchronous active-low reset
//   fire_i, stop_i        one-cycle commands from the frame decoder
//   wr_en_i, wr_op_i,     register write strobe, opcode selecting the
//   wr_val_i              register, and value
//   trg_pls_o             registered trigger pulse
//   busy_o                channel not in IDLE
module ptmch_trg_ch
  import ptmch_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             fire_i,
  input  logic             stop_i,
  input  logic             wr_en_i,
  input  logic [3:0]       wr_op_i,
  input  logic [CNT_W-1:0] wr_val_i,
  output logic             trg_pls_o,
  output logic             busy_o
);

  logic [CNT_W-1:0] delay_q, width_q, period_q;
  logic             mode_q;

  // Shadow copies used while running: pulse length minus one, gap length
  // minus one, repeat flag. The delay is consumed straight into the counter
  // at FIRE, so it needs no shadow.
  logic [CNT_W-1:0] sh_w1_q, sh_gap1_q;
  logic             sh_rep_q;

  logic [CNT_W-1:0] w_eff, w1_load, gap1_load;
  logic             start;

  ch_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pls_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      delay_q  <= '0;
      width_q  <= CNT_W'(1);
      period_q <= '0;
      mode_q   <= 1'b0;
    end else if (wr_en_i) begin
      case (wr_op_i)
        OP_DELAY:  delay_q  <= wr_val_i;
        OP_WIDTH:  width_q  <= wr_val_i;
        OP_PERIOD: period_q <= wr_val_i;
        OP_MODE:   mode_q   <= wr_val_i[0];
        default:   ;
      endcase
    end
  end

  // W=0 runs as W=1; a period not longer than the pulse leaves a one-cycle
  // gap. Computed as P-W directly so W near full scale cannot overflow.
  always_comb begin
    w_eff     = (width_q == '0) ? CNT_W'(1) : width_q;
    w1_load   = w_eff - CNT_W'(1);
    gap1_load = (period_q > w_eff) ? (period_q - w_eff - CNT_W'(1)) : '0;
  end

  assign start = fire_i && !stop_i && (state_q == ST_IDLE);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sh_w1_q   <= '0;
      sh_gap1_q <= '0;
      sh_rep_q  <= 1'b0;
    end else if (start) begin
      sh_w1_q   <= w1_load;
      sh_gap1_q <= gap1_load;
      sh_rep_q  <= mode_q;
    end
  end

  // State register
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      pls_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pls_q   <= (state_d == ST_PULSE);
    end
  end

  // Next-state logic. Counters only ever count down to zero and reload.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (stop_i) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (fire_i) begin
            if (delay_q == '0) begin
              state_d = ST_PULSE;
              cnt_d   = w1_load;
            end else begin
              state_d = ST_DELAY;
              cnt_d   = delay_q - CNT_W'(1);
            end
          end
        end
        ST_DELAY: begin
          if (cnt_q == '0) begin
            state_d = ST_PULSE;
            cnt_d   = sh_w1_q;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        ST_PULSE: begin
          if (cnt_q == '0) begin
            if (sh_rep_q) begin
              state_d = ST_GAP;
              cnt_d   = sh_gap1_q;
            end else begin
              state_d = ST_IDLE;
              cnt_d   = '0;
            end
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        ST_GAP: begin
          if (cnt_q == '0) begin
            state_d = ST_PULSE;
            cnt_d   = sh_w1_q;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Outputs
  always_comb begin
    trg_pls_o = pls_q;
    busy_o    = (state_q != ST_IDLE);
  end

endmodule

// File: rtl/ptmch_trg_mc.sv
// ptmch_trg_mc: SPI-programmed multi-channel trigger pulse generator.
// An SPI mode-0 slave (sampled by oversampling on CLK160M) receives 24-bit
// frames {channel[3:0], opcode[3:0], value[15:0]} that program and fire
// N_CH independent trigger channels.
// Ports:
//   CLK160M    sole clock
//   RESET_N    synchronous active-low reset
//   SPI_CS     chip select, active-low, asynchronous
//   SPI_CLK    SPI clock, asynchronous
//   SPI_MOSI   SPI data, MSB first
//   TRG_PLS    per-channel registered trigger pulse
//   BUSY       per-channel "not idle"
//   FRAME_ERR  one-cycle pulse when a frame is rejected
module ptmch_trg_mc
  import ptmch_pkg::*;
#(
  parameter int N_CH  = 4,
  parameter int CNT_W = 16
) (
  input  logic            CLK160M,
  input  logic            RESET_N,
  input  logic            SPI_CS,
  input  logic            SPI_CLK,
  input  logic            SPI_MOSI,
  output logic [N_CH-1:0] TRG_PLS,
  output logic [N_CH-1:0] BUSY,
  output logic            FRAME_ERR
);

  localparam logic [4:0] N_CH_L = 5'(N_CH);

  // Two synchroniser stages plus one history stage for edge detection.
  // CS resets to 0 so that a frame in flight across reset never shows a
  // falling edge; its closing rising edge is then ignored (not armed).
  logic [2:0] cs_sync_q, sclk_sync_q;
  logic [1:0] mosi_sync_q;
  logic       sclk_rise, cs_fall, cs_rise, cs_low, mosi_s;

  logic [FRAME_W-1:0] shreg_q;
  logic [4:0]         bitcnt_q;
  logic               armed_q;

  logic [3:0]      ch_idx, op;
  logic            ch_ok, bcast;
  logic [N_CH-1:0] chan_sel, tgt;
  logic [N_CH-1:0] fire_d, stop_d, wr_en_d;
  logic            err_d;

  logic [N_CH-1:0]  fire_q, stop_q, wr_en_q;
  logic [3:0]       wr_op_q;
  logic [CNT_W-1:0] wr_val_q;
  logic             frame_err_q;

  always_ff @(posedge CLK160M) begin
    if (!RESET_N) begin
      cs_sync_q   <= '0;
      sclk_sync_q <= '0;
      mosi_sync_q <= '0;
    end else begin
      cs_sync_q   <= {cs_sync_q[1:0], SPI_CS};
      sclk_sync_q <= {sclk_sync_q[1:0], SPI_CLK};
      mosi_sync_q <= {mosi_sync_q[0], SPI_MOSI};
    end
  end

  assign cs_low    = ~cs_sync_q[1];
  assign mosi_s    = mosi_sync_q[1];
  assign sclk_rise = sclk_sync_q[1] & ~sclk_sync_q[2];
  assign cs_fall   = ~cs_sync_q[1] & cs_sync_q[2];
  assign cs_rise   = cs_sync_q[1] & ~cs_sync_q[2];

  // Bit count saturates so an overlong frame can never alias to 24.
  always_ff @(posedge CLK160M) begin
    if (!RESET_N) begin
      shreg_q  <= '0;
      bitcnt_q <= '0;
      armed_q  <= 1'b0;
    end else if (cs_fall) begin
      bitcnt_q <= '0;
      armed_q  <= 1'b1;
    end else if (sclk_rise && cs_low) begin
      shreg_q <= {shreg_q[FRAME_W-2:0], mosi_s};
      if (bitcnt_q != '1) bitcnt_q <= bitcnt_q + 5'd1;
    end
  end

  assign ch_idx = shreg_q[23:20];
  assign op     = shreg_q[19:16];
  assign ch_ok  = ({1'b0, ch_idx} < N_CH_L);
  assign bcast  = (ch_idx == BCAST_CH);

  // Decode in the CS rising-edge cycle; the registered result is the commit
  // cycle seen by the channels and on FRAME_ERR.
  always_comb begin
    fire_d  = '0;
    stop_d  = '0;
    wr_en_d = '0;
    err_d   = 1'b0;
    tgt     = '0;
    if (cs_rise && armed_q && (bitcnt_q != '0)) begin
      if (bitcnt_q != 5'(FRAME_W)) begin
        err_d = 1'b1;
      end else if (is_reg_write(op)) begin
        if (ch_ok) wr_en_d = chan_sel;
        else       err_d   = 1'b1;
      end else if ((op == OP_FIRE) || (op == OP_STOP)) begin
        if (bcast)      tgt   = '1;
        else if (ch_ok) tgt   = chan_sel;
        else            err_d = 1'b1;
        if (op == OP_FIRE) fire_d = tgt;
        else               stop_d = tgt;
      end else begin
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK160M) begin
    if (!RESET_N) begin
      fire_q      <= '0;
      stop_q      <= '0;
      wr_en_q     <= '0;
      wr_op_q     <= '0;
      wr_val_q    <= '0;
      frame_err_q <= 1'b0;
    end else begin
      fire_q      <= fire_d;
      stop_q      <= stop_d;
      wr_en_q     <= wr_en_d;
      wr_op_q     <= op;
      wr_val_q    <= shreg_q[CNT_W-1:0];
      frame_err_q <= err_d;
    end
  end

  assign FRAME_ERR = frame_err_q;

  for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
    assign chan_sel[gi] = (ch_idx == 4'(gi));

    ptmch_trg_ch #(
      .CNT_W(CNT_W)
    ) u_ch (
      .clk_i    (CLK160M),
      .rst_ni   (RESET_N),
      .fire_i   (fire_q[gi]),
      .stop_i   (stop_q[gi]),
      .wr_en_i  (wr_en_q[gi]),
      .wr_op_i  (wr_op_q),
      .wr_val_i (wr_val_q),
      .trg_pls_o(TRG_PLS[gi]),
      .busy_o   (BUSY[gi])
    );
  end

endmodule
